// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus/mie/mtvec/mepc/mip, 64-bit mcycle/minstret,
// interrupt trap/MRET redirect generation and the WFI sleep state machine.
module csr_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        csr_we,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    input  logic        instr_retire,
    input  logic        mret,
    input  logic        wfi,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic [31:0] cur_pc,
    output logic        trap_take,
    output logic        mret_take,
    output logic [31:0] redirect_pc,
    output logic        stall_wfi
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_MINSTR   = 12'hB02;
    localparam logic [11:0] A_MINSTRH  = 12'hB82;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
    localparam logic [11:0] A_INSTR    = 12'hC02;
    localparam logic [11:0] A_INSTRH   = 12'hC82;
    localparam logic [31:0] MTVEC_VAL  = 32'h0001_0000;

    typedef struct packed {
        logic        we;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
    } csr_req_t;

    typedef enum logic {RUN, SLEEP} state_t;

    csr_req_t    req;
    state_t      state, state_nxt;
    logic        st_mie, st_mpie;
    logic        ie_meie, ie_mtie;
    logic        ip_meip, ip_mtip;
    logic [31:0] mepc;
    logic [63:0] mcycle, minstret;
    logic [31:0] mstatus_val, mie_val, mip_val, wval;
    logic        wr_en, pending, irq_en;

    assign req = '{we: csr_we, op: csr_op, addr: csr_addr, wdata: csr_wdata};

    // MPP is hardwired to machine mode, so it always reads back as 2'b11
    assign mstatus_val = {19'd0, 2'b11, 3'd0, st_mpie, 3'd0, st_mie, 3'd0};
    assign mie_val     = {20'd0, ie_meie, 3'd0, ie_mtie, 7'd0};
    assign mip_val     = {20'd0, ip_meip, 3'd0, ip_mtip, 7'd0};

    // Combinational read mux; unimplemented addresses read zero
    always_comb begin
        csr_rdata = 32'd0;
        case (req.addr)
            A_MSTATUS:            csr_rdata = mstatus_val;
            A_MIE:                csr_rdata = mie_val;
            A_MTVEC:              csr_rdata = MTVEC_VAL;
            A_MEPC:               csr_rdata = mepc;
            A_MIP:                csr_rdata = mip_val;
            A_MCYCLE,  A_CYCLE:   csr_rdata = mcycle[31:0];
            A_MCYCLEH, A_CYCLEH:  csr_rdata = mcycle[63:32];
            A_MINSTR,  A_INSTR:   csr_rdata = minstret[31:0];
            A_MINSTRH, A_INSTRH:  csr_rdata = minstret[63:32];
            default:              csr_rdata = 32'd0;
        endcase
    end

    // Read-modify-write value; the old value is whatever the read mux shows
    always_comb begin
        wval = csr_rdata;
        case (req.op)
            2'b01:   wval = req.wdata;
            2'b10:   wval = csr_rdata | req.wdata;
            2'b11:   wval = csr_rdata & ~req.wdata;
            default: wval = csr_rdata;
        endcase
    end

    assign wr_en   = req.we && (req.op != 2'b00);
    assign pending = (ip_meip & ie_meie) | (ip_mtip & ie_mtie);
    assign irq_en  = pending & st_mie;

    // A CSR write or MRET in flight pushes any trap to a later cycle
    assign trap_take   = rst_n & irq_en & ~req.we & ~mret;
    assign mret_take   = rst_n & mret & ~req.we;
    assign redirect_pc = trap_take ? MTVEC_VAL : (mret_take ? mepc : 32'd0);
    assign stall_wfi   = (state == SLEEP);

    // Sleep state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_nxt;
    end

    // WFI with an interrupt already pending is a no-op; wake ignores MIE
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (wfi && !pending) state_nxt = SLEEP;
            SLEEP:   if (pending)         state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // mstatus / mie / mepc: software write beats MRET beats trap entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie  <= 1'b0;
            st_mpie <= 1'b0;
            ie_meie <= 1'b0;
            ie_mtie <= 1'b0;
            mepc    <= 32'd0;
        end else begin
            if (wr_en && req.addr == A_MSTATUS) begin
                st_mie  <= wval[3];
                st_mpie <= wval[7];
            end else if (mret_take) begin
                st_mie  <= st_mpie;
                st_mpie <= 1'b1;
            end else if (trap_take) begin
                st_mpie <= st_mie;
                st_mie  <= 1'b0;
            end
            if (wr_en && req.addr == A_MIE) begin
                ie_meie <= wval[11];
                ie_mtie <= wval[7];
            end
            if (wr_en && req.addr == A_MEPC) mepc <= wval & ~32'h3;
            else if (trap_take)              mepc <= cur_pc & ~32'h3;
        end
    end

    // Interrupt lines are sampled into mip every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ip_meip <= 1'b0;
            ip_mtip <= 1'b0;
        end else begin
            ip_meip <= ext_irq;
            ip_mtip <= timer_irq;
        end
    end

    // Counters: a write to one half wins over the increment, other half holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcycle   <= 64'd0;
            minstret <= 64'd0;
        end else begin
            if (wr_en && req.addr == A_MCYCLE)       mcycle <= {mcycle[63:32], wval};
            else if (wr_en && req.addr == A_MCYCLEH) mcycle <= {wval, mcycle[31:0]};
            else                                     mcycle <= mcycle + 64'd1;
            if (wr_en && req.addr == A_MINSTR)       minstret <= {minstret[63:32], wval};
            else if (wr_en && req.addr == A_MINSTRH) minstret <= {wval, minstret[31:0]};
            else if (instr_retire)                   minstret <= minstret + 64'd1;
        end
    end
endmodule
